// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: reads 16-bit halfwords, assembles 16/32-bit instructions for decode.
// Optional performance counters are enabled with `define FETCH_SEQ_PERF_EN.
module fetch_sequencer #(
   parameter int                ADDR_W   = 24,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [15:0]       mem_rdata,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [31:0]       fetchoutput,
   output logic [ADDR_W-1:0] fetch_pc,
   output logic              fetch_valid,
   input  logic              decode_ready
`ifdef FETCH_SEQ_PERF_EN
   ,
   output logic [31:0]       perf_instr_cnt,
   output logic [31:0]       perf_stall_cnt
`endif
);

   typedef enum logic [2:0] {REQ_HI, WAIT_HI, REQ_LO, WAIT_LO, HOLD} state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_next;
   logic [14:0]       hi;
   logic              discard;

   // bit 31 of the held word is the long flag, so it also selects the pc step
   assign pc_next = pc + (fetchoutput[31] ? ADDR_W'(2) : ADDR_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= REQ_HI;
         pc          <= RESET_PC;
         hi          <= '0;
         discard     <= 1'b0;
         mem_req     <= 1'b0;
         mem_addr    <= RESET_PC;
         fetchoutput <= '0;
         fetch_pc    <= '0;
         fetch_valid <= 1'b0;
      end else if (redirect) begin
         pc          <= redirect_pc;
         fetch_valid <= 1'b0;
         state       <= REQ_HI;
         case (state)
            REQ_HI, REQ_LO: begin
               if (mem_req && mem_gnt) begin
                  discard <= 1'b1;
                  mem_req <= 1'b0;
               end else if (discard && !mem_rvalid) begin
                  mem_addr <= redirect_pc;
               end else begin
                  discard  <= 1'b0;
                  mem_req  <= 1'b1;
                  mem_addr <= redirect_pc;
               end
            end
            WAIT_HI, WAIT_LO: begin
               // a response landing with the redirect is simply dropped
               if (mem_rvalid) begin
                  mem_req  <= 1'b1;
                  mem_addr <= redirect_pc;
               end else begin
                  discard  <= 1'b1;
               end
            end
            default: begin
               mem_req  <= 1'b1;
               mem_addr <= redirect_pc;
            end
         endcase
      end else begin
         case (state)
            REQ_HI: begin
               if (discard) begin
                  if (mem_rvalid) begin
                     discard  <= 1'b0;
                     mem_req  <= 1'b1;
                     mem_addr <= pc;
                  end
               end else if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_addr <= pc;
               end else if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= WAIT_HI;
               end
            end
            WAIT_HI: begin
               if (mem_rvalid) begin
                  hi <= mem_rdata[14:0];
                  if (!mem_rdata[15]) begin
                     fetchoutput <= {1'b0, mem_rdata[14:0], 16'h0000};
                     fetch_pc    <= pc;
                     fetch_valid <= 1'b1;
                     state       <= HOLD;
                  end else begin
                     mem_req  <= 1'b1;
                     mem_addr <= pc + ADDR_W'(1);
                     state    <= REQ_LO;
                  end
               end
            end
            REQ_LO: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= WAIT_LO;
               end
            end
            WAIT_LO: begin
               if (mem_rvalid) begin
                  fetchoutput <= {1'b1, hi, mem_rdata};
                  fetch_pc    <= pc;
                  fetch_valid <= 1'b1;
                  state       <= HOLD;
               end
            end
            default: begin
               if (decode_ready) begin
                  fetch_valid <= 1'b0;
                  pc          <= pc_next;
                  mem_req     <= 1'b1;
                  mem_addr    <= pc_next;
                  state       <= REQ_HI;
               end
            end
         endcase
      end
   end

`ifdef FETCH_SEQ_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_instr_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (fetch_valid && decode_ready)  perf_instr_cnt <= perf_instr_cnt + 32'd1;
         if (fetch_valid && !decode_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a behavioural halfword memory plus an expected-instruction queue.
module tb_fetch_sequencer;

   logic        clk, rst_n;
   logic        mem_req, mem_gnt, mem_rvalid;
   logic [23:0] mem_addr, redirect_pc, fetch_pc;
   logic [15:0] mem_rdata;
   logic        redirect, fetch_valid, decode_ready;
   logic [31:0] fetchoutput;
`ifdef FETCH_SEQ_PERF_EN
   logic [31:0] perf_instr_cnt, perf_stall_cnt;
`endif

   fetch_sequencer #(.ADDR_W(24), .RESET_PC(24'h10)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .fetchoutput(fetchoutput), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
      .decode_ready(decode_ready)
`ifdef FETCH_SEQ_PERF_EN
      , .perf_instr_cnt(perf_instr_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   typedef struct {
      logic [31:0] w;
      logic [23:0] pc;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] img [logic [23:0]];
   logic [23:0] mpc;
   int          errors = 0, checks = 0;
   int          xfers = 0, m_instr = 0, m_stall = 0;
   int          lat = 1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] rd(input logic [23:0] a);
      if (img.exists(a)) return img[a];
      return {1'b0, a[14:0]};
   endfunction

   function automatic logic [31:0] exp_word(input logic [23:0] a);
      logic [15:0] h, l;
      h = rd(a);
      l = rd(a + 24'd1);
      return h[15] ? {1'b1, h[14:0], l} : {1'b0, h[14:0], 16'h0000};
   endfunction

   task automatic push_next();
      exp_t e;
      e.w  = exp_word(mpc);
      e.pc = mpc;
      sb.push_back(e);
      mpc = mpc + (e.w[31] ? 24'd2 : 24'd1);
   endtask

   // memory: grants any request when idle, answers lat cycles after the grant
   initial begin
      bit          pend;
      int          cnt;
      logic [23:0] paddr;
      pend = 0; cnt = 0; paddr = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      forever begin
         @(posedge clk); #2;
         mem_gnt = 1'b0; mem_rvalid = 1'b0;
         if (pend) begin
            if (cnt <= 1) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rd(paddr);
               pend       = 0;
            end else cnt--;
         end
         if (rst_n && mem_req && !pend) begin
            mem_gnt = 1'b1;
            pend    = 1;
            paddr   = mem_addr;
            cnt     = lat;
         end
      end
   end

   // decode side: every transfer is popped and compared
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_instr = 0; m_stall = 0;
         end else if (fetch_valid && decode_ready) begin
            xfers++; m_instr++;
            if (sb.size() == 0) chk("unexpected_xfer", sb.size(), 1);
            else begin
               e = sb.pop_front();
               chk("xfer_word", fetchoutput, e.w);
               chk("xfer_pc", fetch_pc, e.pc);
            end
         end else if (fetch_valid) m_stall++;
      end
   end

   task automatic run(input int n);
      int tgt, cyc;
      for (int i = 0; i < n; i++) push_next();
      tgt = xfers + n;
      cyc = 0;
      decode_ready = 1'b1;
      while (xfers < tgt && cyc < 300) begin
         @(posedge clk); #1; cyc++;
      end
      decode_ready = 1'b0;
      chk("run_done", xfers, tgt);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!fetch_valid && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("wait_valid", fetch_valid, 1);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_req"}, mem_req, 0);
      chk({tag, "_addr"}, mem_addr, 24'h10);
      chk({tag, "_valid"}, fetch_valid, 0);
      chk({tag, "_word"}, fetchoutput, 0);
      chk({tag, "_pc"}, fetch_pc, 0);
`ifdef FETCH_SEQ_PERF_EN
      chk({tag, "_pinstr"}, perf_instr_cnt, 0);
      chk({tag, "_pstall"}, perf_stall_cnt, 0);
`endif
   endtask

   initial begin
      int n, g;
      bit seen;
      rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; decode_ready = 1'b0;
      img[24'h10]     = 16'h1234;
      img[24'h20]     = 16'h8A05;
      img[24'h21]     = 16'hBEEF;
      img[24'h100]    = 16'h7777;
      img[24'hFFFFFF] = 16'h9ABC;
      img[24'h000000] = 16'h4321;
      img[24'h200]    = 16'hC001;
      img[24'h201]    = 16'h5555;

      repeat (3) @(posedge clk);
      #1;
      check_reset("rst");
      rst_n = 1'b1;

      // first fetch and its 2-cycle latency
      @(posedge clk); #1;
      chk("req_rise", mem_req, 1);
      chk("req_addr", mem_addr, 24'h10);
      @(posedge clk); #1;
      chk("lat_early", fetch_valid, 0);
      @(posedge clk); #1;
      chk("lat_valid", fetch_valid, 1);
      chk("first_word", fetchoutput, 32'h12340000);
      chk("first_pc", fetch_pc, 24'h10);
      mpc = 24'h10;
      run(1);
      chk("next_req", mem_req, 1);
      chk("next_addr", mem_addr, 24'h11);

      // run through short fillers to the long instruction at 0x20
      run(15);
      wait_valid();
      chk("long_word", fetchoutput, 32'h8A05BEEF);
      chk("long_pc", fetch_pc, 24'h20);
      run(1);
      chk("long_next", mem_addr, 24'h22);

      // back-pressure: output frozen, no memory traffic
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", fetch_valid, 1);
         chk("bp_word", fetchoutput, 32'h00220000);
         chk("bp_req", mem_req, 0);
         @(posedge clk); #1;
      end
      run(1);

      // redirect while the read is in flight
      lat = 3;
      n = 0;
      while (!mem_gnt && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk("rd_gnt_seen", mem_gnt, 1);
      redirect = 1'b1; redirect_pc = 24'h100;
      @(posedge clk); #1;
      redirect = 1'b0;
      chk("rd_hold_req", mem_req, 0);
      mpc = 24'h100;
      seen = 0; n = 0;
      while (!mem_req && n < 50) begin
         if (fetch_valid) seen = 1;
         @(posedge clk); #1; n++;
      end
      chk("rd_stale_valid", seen, 0);
      chk("rd_req", mem_req, 1);
      chk("rd_addr", mem_addr, 24'h100);
      lat = 1;
      run(2);

      // redirect from HOLD to the top of the address space, long instr wraps
      wait_valid();
      redirect = 1'b1; redirect_pc = 24'hFFFFFF;
      @(posedge clk); #1;
      redirect = 1'b0;
      chk("wrap_req", mem_req, 1);
      chk("wrap_addr", mem_addr, 24'hFFFFFF);
      chk("wrap_valid", fetch_valid, 0);
      mpc = 24'hFFFFFF;
      wait_valid();
      chk("wrap_word", fetchoutput, 32'h9ABC4321);
      chk("wrap_pc", fetch_pc, 24'hFFFFFF);
      run(2);

      // reset while waiting on the low half
      wait_valid();
      lat = 3;
      redirect = 1'b1; redirect_pc = 24'h200;
      @(posedge clk); #1;
      redirect = 1'b0;
      n = 0; g = 0;
      while (g < 2 && n < 60) begin
         @(posedge clk); #1; n++;
         if (mem_gnt) g++;
      end
      chk("rst_lo_gnt", g, 2);
      chk("rst_lo_addr", mem_addr, 24'h201);
      rst_n = 1'b0;
      #1;
      check_reset("mid");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      lat = 1;
      mpc = 24'h10;
      run(1);

      chk("sb_drained", sb.size(), 0);
`ifdef FETCH_SEQ_PERF_EN
      chk("perf_instr", perf_instr_cnt, m_instr);
      chk("perf_stall", perf_stall_cnt, m_stall);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
